// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the ALU instruction sequencer: state encoding,
// opcode constants and opcode classification helpers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // ALU function used during fetch to compute PC + 1 into Z.
  localparam logic [4:0] ALU_INC = 5'b11111;

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_binary(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHR) || (op == OP_SHL);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_binary(op) || is_unary(op);
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Memory wait counter for the T2 fetch state. Cleared before each fetch,
// counts cycles without mem_ready, and flags the final allowed wait cycle.
module seq_wait_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count_q;

  // Count stalled cycles; clear has priority over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CW'(1);
    end
  end

  // The cycle holding LIMIT-1 is the last one in which mem_ready may still arrive.
  assign expired = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle fetch/execute sequencer for register-register ALU instructions
// on the single-bus datapath. Strobes are decoded from state; done and fault
// are registered one-cycle pulses.
module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [31:0]    ir,
  input  logic           mem_ready,
  output logic           busy,
  output logic           done,
  output logic           fault,
  output logic           pc_out,
  output logic           mar_in,
  output logic           inc_pc,
  output logic           pc_in,
  output logic           mem_read,
  output logic           mdr_in,
  output logic           mdr_out,
  output logic           ir_in,
  output logic           y_in,
  output logic           z_in,
  output logic           zlow_out,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_out,
  output logic           r_in,
  output logic [OPW-1:0] alu_op
);

  state_e     state;
  logic [4:0] opcode;
  logic       unused_ir;
  logic       wait_clear;
  logic       wait_enable;
  logic       wait_expired;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  assign wait_clear  = (state == StT1);
  assign wait_enable = (state == StT2) && !mem_ready;

  seq_wait_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (wait_expired)
  );

  // State sequencing with registered done/fault pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      done  <= 1'b0;
      fault <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state)
        StIdle: if (start) state <= StT0;
        StT0:   state <= StT1;
        StT1:   state <= StT2;
        StT2: begin
          // mem_ready wins over expiry on the final wait cycle.
          if (mem_ready) begin
            state <= StT3;
          end else if (wait_expired) begin
            fault <= 1'b1;
            state <= StIdle;
          end
        end
        StT3:   state <= StT4;
        StT4: begin
          if (is_unary(opcode)) begin
            state <= StT6;
          end else if (is_legal(opcode)) begin
            state <= StT5;
          end else begin
            fault <= 1'b1;
            state <= StIdle;
          end
        end
        StT5:   state <= StT6;
        StT6: begin
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Datapath strobe decode from the current state (and opcode in T4/T5).
  always_comb begin
    busy     = (state != StIdle);
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    pc_in    = 1'b0;
    mem_read = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    r_out    = 1'b0;
    r_in     = 1'b0;
    alu_op   = '0;
    unique case (state)
      StT0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        z_in   = 1'b1;
        alu_op = OPW'(ALU_INC);
      end
      StT1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
      end
      StT2: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      StT3: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      StT4: begin
        if (is_unary(opcode)) begin
          grb    = 1'b1;
          r_out  = 1'b1;
          z_in   = 1'b1;
          alu_op = OPW'(opcode);
        end else if (is_legal(opcode)) begin
          grb   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end
      end
      StT5: begin
        grc    = 1'b1;
        r_out  = 1'b1;
        z_in   = 1'b1;
        alu_op = OPW'(opcode);
      end
      StT6: begin
        zlow_out = 1'b1;
        gra      = 1'b1;
        r_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed self-checking bench for alu_instr_sequencer. Every cycle's outputs
// are packed into one word and compared against hand-written per-state words.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic        mem_ready;
  logic        busy, done, fault;
  logic        pc_out, mar_in, inc_pc, pc_in;
  logic        mem_read, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlow_out;
  logic        gra, grb, grc, r_out, r_in;
  logic [4:0]  alu_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_instr_sequencer #(
    .OPW         (5),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ir        (ir),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .pc_out    (pc_out),
    .mar_in    (mar_in),
    .inc_pc    (inc_pc),
    .pc_in     (pc_in),
    .mem_read  (mem_read),
    .mdr_in    (mdr_in),
    .mdr_out   (mdr_out),
    .ir_in     (ir_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .zlow_out  (zlow_out),
    .gra       (gra),
    .grb       (grb),
    .grc       (grc),
    .r_out     (r_out),
    .r_in      (r_in),
    .alu_op    (alu_op)
  );

  // Strobe word bit order, MSB first:
  // pc_out mar_in inc_pc pc_in | mem_read mdr_in mdr_out ir_in |
  // y_in z_in zlow_out gra | grb grc r_out r_in
  logic [15:0] strobes;
  logic [23:0] obs;
  assign strobes = {pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out, ir_in,
                    y_in, z_in, zlow_out, gra, grb, grc, r_out, r_in};
  assign obs = {strobes, alu_op, busy, done, fault};

  localparam logic [15:0] StrIdle = 16'h0000;
  localparam logic [15:0] StrT0   = 16'hC040;  // pc_out mar_in z_in
  localparam logic [15:0] StrT1   = 16'h1020;  // pc_in zlow_out
  localparam logic [15:0] StrT2   = 16'h0C00;  // mem_read mdr_in
  localparam logic [15:0] StrT3   = 16'h0300;  // mdr_out ir_in
  localparam logic [15:0] StrT4b  = 16'h008A;  // y_in grb r_out
  localparam logic [15:0] StrT4u  = 16'h004A;  // z_in grb r_out
  localparam logic [15:0] StrT5   = 16'h0046;  // z_in grc r_out
  localparam logic [15:0] StrT6   = 16'h0031;  // zlow_out gra r_in

  function automatic logic [23:0] ew(input logic [15:0] s, input logic [4:0] a,
                                     input logic b, input logic d, input logic f);
    return {s, a, b, d, f};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ir = 32'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    if (obs !== 24'h0) begin
      $display("FAIL reset_hold: got %h want %h", obs, 24'h0); bad++;
    end
    total++;
    reset = 1'b0;
    @(negedge clk);
    if (obs !== 24'h0) begin
      $display("FAIL reset_release: got %h want %h", obs, 24'h0); bad++;
    end
    total++;
    // Abort in T2 while waiting on memory.
    ir = {5'b00011, 27'h0};
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    if (obs !== ew(StrT2, 5'd0, 1'b1, 1'b0, 1'b0)) begin
      $display("FAIL reset_pre_t2: got %h want %h", obs, ew(StrT2, 5'd0, 1'b1, 1'b0, 1'b0));
      bad++;
    end
    total++;
    #1 reset = 1'b1;
    #1;
    if (obs !== 24'h0) begin
      $display("FAIL reset_async: got %h want %h", obs, 24'h0); bad++;
    end
    total++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (obs !== 24'h0) begin
      $display("FAIL reset_no_pulse: got %h want %h", obs, 24'h0); bad++;
    end
    total++;
    mem_ready = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (obs !== ew(StrT0, 5'b11111, 1'b1, 1'b0, 1'b0)) begin
      $display("FAIL reset_restart_t0: got %h want %h", obs,
               ew(StrT0, 5'b11111, 1'b1, 1'b0, 1'b0));
      bad++;
    end
    total++;
    repeat (10) @(negedge clk);
    if (obs !== 24'h0) begin
      $display("FAIL reset_settle: got %h want %h", obs, 24'h0); bad++;
    end
    total++;
  endtask

  task automatic test_add();
    logic [23:0] exp [9];
    exp = '{ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT3, 0, 1, 0, 0), ew(StrT4b, 0, 1, 0, 0), ew(StrT5, 5'b00011, 1, 0, 0),
            ew(StrT6, 0, 1, 0, 0), ew(StrIdle, 0, 0, 1, 0), ew(StrIdle, 0, 0, 0, 0)};
    ir = {5'b00011, 27'h155}; mem_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); start = 1'b0;
      if (obs !== exp[k]) begin
        $display("FAIL add c%0d: got %h want %h", k + 1, obs, exp[k]); bad++;
      end
      total++;
    end
  endtask

  task automatic test_not();
    logic [23:0] exp [8];
    exp = '{ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT3, 0, 1, 0, 0), ew(StrT4u, 5'b10010, 1, 0, 0), ew(StrT6, 0, 1, 0, 0),
            ew(StrIdle, 0, 0, 1, 0), ew(StrIdle, 0, 0, 0, 0)};
    ir = {5'b10010, 27'h0}; mem_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); start = 1'b0;
      if (obs !== exp[k]) begin
        $display("FAIL not c%0d: got %h want %h", k + 1, obs, exp[k]); bad++;
      end
      total++;
    end
  endtask

  task automatic test_mem_wait();
    logic [23:0] exp [14];
    exp = '{ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0),
            ew(StrT2, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT2, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT3, 0, 1, 0, 0), ew(StrT4b, 0, 1, 0, 0), ew(StrT5, 5'b00110, 1, 0, 0),
            ew(StrT6, 0, 1, 0, 0), ew(StrIdle, 0, 0, 1, 0), ew(StrIdle, 0, 0, 0, 0)};
    ir = {5'b00110, 27'h0}; mem_ready = 1'b0; start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); start = 1'b0;
      if (obs !== exp[k]) begin
        $display("FAIL memwait c%0d: got %h want %h", k + 1, obs, exp[k]); bad++;
      end
      total++;
      // Five stalled T2 cycles, ready sampled at the end of the sixth.
      mem_ready = (k >= 7);
    end
  endtask

  task automatic test_timeout();
    logic [23:0] want;
    ir = {5'b00011, 27'h0}; mem_ready = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); start = 1'b0;
      if (k == 1)       want = ew(StrT0, 5'b11111, 1, 0, 0);
      else if (k == 2)  want = ew(StrT1, 0, 1, 0, 0);
      else if (k <= 18) want = ew(StrT2, 0, 1, 0, 0);
      else if (k == 19) want = ew(StrIdle, 0, 0, 0, 1);
      else              want = ew(StrIdle, 0, 0, 0, 0);
      if (obs !== want) begin
        $display("FAIL timeout c%0d: got %h want %h", k, obs, want); bad++;
      end
      total++;
    end
  endtask

  task automatic test_illegal();
    logic [23:0] exp [8];
    exp = '{ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT3, 0, 1, 0, 0), ew(StrIdle, 0, 1, 0, 0), ew(StrIdle, 0, 0, 0, 1),
            ew(StrIdle, 0, 0, 0, 0), ew(StrIdle, 0, 0, 0, 0)};
    ir = {5'b01111, 27'h0}; mem_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      // start re-asserted while busy must not be remembered.
      start = (k >= 1 && k <= 3);
      if (obs !== exp[k]) begin
        $display("FAIL illegal c%0d: got %h want %h", k + 1, obs, exp[k]); bad++;
      end
      total++;
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp [14];
    exp = '{ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0), ew(StrT2, 0, 1, 0, 0),
            ew(StrT3, 0, 1, 0, 0), ew(StrT4u, 5'b10001, 1, 0, 0), ew(StrT6, 0, 1, 0, 0),
            ew(StrIdle, 0, 0, 1, 0), ew(StrT0, 5'b11111, 1, 0, 0), ew(StrT1, 0, 1, 0, 0),
            ew(StrT2, 0, 1, 0, 0), ew(StrT3, 0, 1, 0, 0), ew(StrT4u, 5'b10001, 1, 0, 0),
            ew(StrT6, 0, 1, 0, 0), ew(StrIdle, 0, 0, 1, 0)};
    ir = {5'b10001, 27'h0}; mem_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 7) start = 1'b0;
      if (obs !== exp[k]) begin
        $display("FAIL b2b c%0d: got %h want %h", k + 1, obs, exp[k]); bad++;
      end
      total++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_not();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
